// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg: shared types and helpers for the oversampling UART blocks.
//   rx_state_e    receiver FSM state encoding
//   PAR_*         parity mode constants for the PARITY parameter
//   par_expected  parity bit a correct frame carries for a data word
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned MAX_DATA_W = 9;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DELIVER,
        ST_BREAK
    } rx_state_e;

    // Data is zero-extended to MAX_DATA_W, which leaves its XOR unchanged.
    function automatic logic par_expected(input logic [MAX_DATA_W-1:0] d,
                                          input int unsigned           mode);
        par_expected = (mode == PAR_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick: divides clk_i by CLK_DIV into a one-clock tick enable.
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   restart_i  realign the divider; first tick follows CLK_DIV clocks later
//   tick_o     registered one-clock tick, every CLK_DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned CLK_DIV = 7
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    // Next count: restart or wrap to 0, otherwise increment.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || (cnt_q == CW'(CLK_DIV - 1))) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Tick is registered off the next count so it lands exactly on the wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CW'(CLK_DIV - 1));
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os: oversampling UART receiver with majority vote and valid/ready out.
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   rx_i          asynchronous serial line, idle high
//   data_o        received word, LSB first on the wire
//   valid_o       data_o and error flags hold a word
//   ready_i       consumer accepts on valid_o && ready_i
//   frame_err_o   a stop bit was sampled low
//   parity_err_o  parity bit mismatch (0 when PARITY = PAR_NONE)
//   overrun_o     one-clock pulse when a finished word is dropped
//   busy_o        receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 7,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_W);
    localparam int unsigned M  = OVERSAMPLE / 2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    rx_state_e              state_q;
    logic [SW-1:0]          samp_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_W-1:0]      shift_q;
    logic [1:0]             vote_q;
    logic                   ferr_q;
    logic                   perr_q;
    logic [DATA_W-1:0]      data_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic                   parity_err_q;
    logic                   overrun_q;

    logic rx_s;
    logic tick;
    logic restart_c;
    logic voted_c;
    logic decide_c;
    logic bit_end_c;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Input synchroniser; resets to idle-high so a low line yields a real edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_prev_q <= rx_s;
        end
    end

    // Start detection, vote and per-bit decision/end strobes.
    always_comb begin
        restart_c = (state_q == ST_IDLE) && rx_prev_q && !rx_s;
        voted_c   = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
        decide_c  = tick && (samp_q == SW'(M + 1));
        bit_end_c = tick && (samp_q == SW'(OVERSAMPLE - 1));
    end

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .restart_i (restart_c),
        .tick_o    (tick)
    );

    // Receive FSM, sample counter, shift register and output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            samp_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            vote_q       <= '0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end

            // Sample index within the bit; the first two vote samples are kept.
            if (tick && (state_q != ST_IDLE)) begin
                samp_q <= (samp_q == SW'(OVERSAMPLE - 1)) ? '0 : samp_q + SW'(1);
                if (samp_q == SW'(M - 1)) vote_q[0] <= rx_s;
                if (samp_q == SW'(M))     vote_q[1] <= rx_s;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (restart_c) begin
                        state_q <= ST_START;
                        samp_q  <= '0;
                        bit_q   <= '0;
                        ferr_q  <= 1'b0;
                        perr_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide_c && voted_c) begin
                        state_q <= ST_IDLE;
                    end else if (bit_end_c) begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                    end
                end
                ST_DATA: begin
                    if (decide_c) begin
                        shift_q <= {voted_c, shift_q[DATA_W-1:1]};
                    end
                    if (bit_end_c) begin
                        if (bit_q == BW'(DATA_W - 1)) begin
                            bit_q   <= '0;
                            state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide_c) begin
                        perr_q <= (voted_c != par_expected(MAX_DATA_W'(shift_q), PARITY));
                    end
                    if (bit_end_c) begin
                        state_q <= ST_STOP;
                        bit_q   <= '0;
                    end
                end
                ST_STOP: begin
                    // Leave at the final stop decision so back-to-back frames fit.
                    if (decide_c) begin
                        if (!voted_c) ferr_q <= 1'b1;
                        if (bit_q == BW'(STOP_BITS - 1)) state_q <= ST_DELIVER;
                    end
                    if (bit_end_c) begin
                        bit_q <= bit_q + BW'(1);
                    end
                end
                ST_DELIVER: begin
                    if (!valid_q || ready_i) begin
                        data_q       <= shift_q;
                        frame_err_q  <= ferr_q;
                        parity_err_q <= perr_q;
                        valid_q      <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    state_q <= (ferr_q && !rx_s) ? ST_BREAK : ST_IDLE;
                end
                ST_BREAK: begin
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os: directed bench for uart_rx_os at 16 clocks per bit.
// Instance "e" uses even parity, instance "o" uses odd parity.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       rx_e = 1'b1, ready_e = 1'b1;
    logic [7:0] data_e;
    logic       valid_e, fe_e, pe_e, ovr_e, busy_e;

    logic       rx_o = 1'b1, ready_o = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, fe_o, pe_o, ovr_o, busy_o;

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLK_DIV(1), .OVERSAMPLE(16), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut_e (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_e), .data_o(data_e), .valid_o(valid_e),
        .ready_i(ready_e), .frame_err_o(fe_e), .parity_err_o(pe_e), .overrun_o(ovr_e),
        .busy_o(busy_e)
    );

    uart_rx_os #(
        .CLK_DIV(1), .OVERSAMPLE(16), .DATA_W(8), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut_o (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_o), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_o), .frame_err_o(fe_o), .parity_err_o(pe_o), .overrun_o(ovr_o),
        .busy_o(busy_o)
    );

    // Monitor: accepted words {frame_err, parity_err, data}, valid cycles, overruns.
    logic [9:0] q_e[$];
    logic [9:0] q_o[$];
    int vcyc_e = 0, novr_e = 0, novr_o = 0;

    always @(negedge clk) begin
        if (valid_e) vcyc_e++;
        if (valid_e && ready_e) q_e.push_back({fe_e, pe_e, data_e});
        if (ovr_e) novr_e++;
        if (valid_o && ready_o) q_o.push_back({fe_o, pe_o, data_o});
        if (ovr_o) novr_o++;
    end

    int n_chk = 0, n_bad = 0;
    int rd_e = 0, rd_o = 0;
    int v0, o0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One bit = 16 clocks; jit inverts clock 9 of the bit, which the DUT reads
    // as oversample tick 8 (the vote midpoint) given the 2-flop synchroniser.
    task automatic send_bit(input bit sel, input logic v, input bit jit);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (sel) rx_o = (jit && i == 9) ? ~v : v;
            else     rx_e = (jit && i == 9) ? ~v : v;
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input logic p, input bit jit);
        send_bit(sel, 1'b0, jit);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], jit);
        send_bit(sel, p, jit);
        send_bit(sel, 1'b1, jit);
    endtask

    task automatic pop_e(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        logic [9:0] w;
        check({tag, "_cnt"}, q_e.size(), rd_e + 1);
        if (q_e.size() > rd_e) begin
            w = q_e[rd_e];
            rd_e++;
            check({tag, "_data"}, {24'd0, w[7:0]}, {24'd0, d});
            check({tag, "_ferr"}, {31'd0, w[9]}, {31'd0, fe});
            check({tag, "_perr"}, {31'd0, w[8]}, {31'd0, pe});
        end
    endtask

    task automatic pop_o(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        logic [9:0] w;
        check({tag, "_cnt"}, q_o.size(), rd_o + 1);
        if (q_o.size() > rd_o) begin
            w = q_o[rd_o];
            rd_o++;
            check({tag, "_data"}, {24'd0, w[7:0]}, {24'd0, d});
            check({tag, "_ferr"}, {31'd0, w[9]}, {31'd0, fe});
            check({tag, "_perr"}, {31'd0, w[8]}, {31'd0, pe});
        end
    endtask

    initial begin
        wait_clks(3);
        #1 rst = 1'b0;
        wait_clks(2);
        #1;
        check("rst_data",  {24'd0, data_e}, 32'd0);
        check("rst_valid", {31'd0, valid_e}, 32'd0);
        check("rst_ferr",  {31'd0, fe_e}, 32'd0);
        check("rst_perr",  {31'd0, pe_e}, 32'd0);
        check("rst_ovr",   {31'd0, ovr_e}, 32'd0);
        check("rst_busy",  {31'd0, busy_e}, 32'd0);

        // 0xA5 even parity (four ones -> parity 0), consumer always ready.
        v0 = vcyc_e;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0);
        wait_clks(40);
        pop_e("a5", 8'hA5, 1'b0, 1'b0);
        check("a5_vcyc", 32'(vcyc_e - v0), 32'd1);

        // Three back-to-back frames with consumer stalled: first kept, two dropped.
        ready_e = 1'b0;
        o0 = novr_e;
        send_frame(1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
        wait_clks(40);
        #1;
        check("b2b_valid", {31'd0, valid_e}, 32'd1);
        check("b2b_data",  {24'd0, data_e}, 32'd0);
        check("b2b_ovr",   32'(novr_e - o0), 32'd2);
        @(posedge clk); #1 ready_e = 1'b1;
        @(posedge clk); #1 ready_e = 1'b0;
        wait_clks(2);
        #1;
        pop_e("b2b", 8'h00, 1'b0, 1'b0);
        check("b2b_drain", {31'd0, valid_e}, 32'd0);
        ready_e = 1'b1;

        // 4-clock low glitch: start rejected by the vote.
        v0 = vcyc_e;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1 rx_e = 1'b0; end
        @(posedge clk); #1 rx_e = 1'b1;
        wait_clks(3);
        #1;
        check("glitch_busy", {31'd0, busy_e}, 32'd1);
        wait_clks(30);
        #1;
        check("glitch_idle", {31'd0, busy_e}, 32'd0);
        check("glitch_vcyc", 32'(vcyc_e - v0), 32'd0);

        // Odd parity: 0x01 needs parity bit 0; bit 1 must flag an error.
        send_frame(1'b1, 8'h01, 1'b1, 1'b0);
        wait_clks(40);
        pop_o("odd_bad", 8'h01, 1'b0, 1'b1);
        send_frame(1'b1, 8'h01, 1'b0, 1'b0);
        wait_clks(40);
        pop_o("odd_ok", 8'h01, 1'b0, 1'b0);

        // Break: line low 12 bit times, then a clean 0x55.
        @(posedge clk); #1 rx_e = 1'b0;
        wait_clks(192);
        #1;
        check("brk_busy", {31'd0, busy_e}, 32'd1);
        pop_e("brk", 8'h00, 1'b1, 1'b0);
        rx_e = 1'b1;
        wait_clks(10);
        #1;
        check("brk_idle", {31'd0, busy_e}, 32'd0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0);
        wait_clks(40);
        pop_e("after_brk", 8'h55, 1'b0, 1'b0);

        // Single-sample inversion at each bit midpoint, 0x96 (four ones -> parity 0).
        send_frame(1'b0, 8'h96, 1'b0, 1'b1);
        wait_clks(40);
        pop_e("jit", 8'h96, 1'b0, 1'b0);

        // Hold a word, reset mid-DATA of the next frame, then receive 0x42.
        ready_e = 1'b0;
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0);
        wait_clks(40);
        #1;
        check("hold_data", {24'd0, data_e}, 32'h5A);
        o0 = novr_e;
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, i == 1, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("mid_rst_data",  {24'd0, data_e}, 32'd0);
        check("mid_rst_valid", {31'd0, valid_e}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy_e}, 32'd0);
        check("mid_rst_ferr",  {31'd0, fe_e}, 32'd0);
        rx_e = 1'b1;
        wait_clks(3);
        #1 rst = 1'b0;
        ready_e = 1'b1;
        wait_clks(5);
        send_frame(1'b0, 8'h42, 1'b0, 1'b0);
        wait_clks(40);
        pop_e("post_rst", 8'h42, 1'b0, 1'b0);
        check("post_rst_ovr", 32'(novr_e - o0), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
